// File: rtl/tty_pkg.sv
// Shared types and constants for the paced TTY write queue.
// TTY_LF2CR_EN: when defined, stored 0x0A characters are rewritten to 0x0D.
package tty_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } tty_state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_HOLD_CYC = 4;
  localparam int unsigned DEF_GAP_CYC  = 4;

  // Character translation applied on the way into the FIFO.
  function automatic logic [7:0] map_char(input logic [7:0] c);
`ifdef TTY_LF2CR_EN
    return (c == CHAR_LF) ? CHAR_CR : c;
`else
    return c;
`endif
  endfunction

endpackage

// File: rtl/tty_fifo.sv
// Synchronous FIFO with wrap-bit pointers; overfull pushes are ignored unless a
// pop frees a slot in the same cycle.
module tty_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + LVL_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tty_write_queue.sv
// Buffers CPU character stores and replays them as paced tty_write pulses
// (HOLD_CYC high, GAP_CYC low). TTY_LF2CR_EN enables LF-to-CR translation.
module tty_write_queue
  import tty_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             cpu_we,
  input  logic [7:0]       cpu_data,
  input  logic             ovf_clr,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [31:0]      tty_data,
  output logic             tty_write
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  tty_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  char_q, char_d;
  logic        tty_write_q, tty_write_d;
  logic        overflow_q, overflow_d;
  logic        pop_c;
  logic [7:0]  head_c;

  tty_fifo #(
    .DEPTH (DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk   (clk_50mhz),
    .rst_n (rst),
    .push  (cpu_we),
    .pop   (pop_c),
    .wdata (map_char(cpu_data)),
    .rdata (head_c),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty)          state_d = ASSERT;
      ASSERT:  if (cnt_q == '0)     state_d = GAP;
      GAP:     if (cnt_q == '0)     state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_c       = 1'b0;
    tty_write_d = tty_write_q;
    char_d      = char_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        tty_write_d = 1'b0;
        if (!empty) begin
          pop_c       = 1'b1;
          char_d      = head_c;
          tty_write_d = 1'b1;
          cnt_d       = CW'(HOLD_CYC - 1);
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          tty_write_d = 1'b0;
          cnt_d       = CW'(GAP_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: begin
        tty_write_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // A dropped store beats a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (cpu_we && full && !pop_c) overflow_d = 1'b1;
    else if (ovf_clr)             overflow_d = 1'b0;
  end

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      char_q      <= '0;
      tty_write_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      tty_write_q <= tty_write_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tty_write = tty_write_q;
  assign tty_data  = {24'h0, char_q};
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tty_write_queue.sv
// Self-checking bench for tty_write_queue: cycle model feeds an expected-character
// queue that is consumed on every tty_write rising edge.
module tb_tty_write_queue;

  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int GAP   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_data = 8'h00;
  logic        ovf_clr = 1'b0;
  logic        full, empty, overflow, tty_write;
  logic [4:0]  level;
  logic [31:0] tty_data;

  tty_write_queue dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_data  (cpu_data),
    .ovf_clr   (ovf_clr),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .tty_data  (tty_data),
    .tty_write (tty_write)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  function automatic logic [7:0] exp_char(input logic [7:0] c);
`ifdef TTY_LF2CR_EN
    return (c == 8'h0A) ? 8'h0D : c;
`else
    return c;
`endif
  endfunction

  // Reference model of occupancy and pacing cadence (one pop per HOLD+GAP+1 cycles).
  logic [7:0] exp_q[$];
  int   m_level;
  int   m_busy;
  logic m_ovf;
  logic m_pop, m_full, m_acc;

  assign m_pop  = (m_busy == 0) && (m_level != 0);
  assign m_full = (m_level == DEPTH);
  assign m_acc  = cpu_we && (!m_full || m_pop);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_level <= 0;
      m_busy  <= 0;
      m_ovf   <= 1'b0;
      exp_q.delete();
    end else begin
      if (m_acc) exp_q.push_back(exp_char(cpu_data));
      if (cpu_we && !m_acc) m_ovf <= 1'b1;
      else if (ovf_clr)     m_ovf <= 1'b0;
      m_level <= m_level + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_pop)            m_busy <= HOLD + GAP;
      else if (m_busy != 0) m_busy <= m_busy - 1;
    end
  end

  logic        prev_w;
  int          hi_cnt, lo_cnt, n_pulses, max_level;
  logic        lo_valid, gap_check_en;
  logic [31:0] held;
  logic [7:0]  exp_c;

  // Advance one cycle and score any pulse edge seen at the falling clock.
  task automatic step();
    @(negedge clk);
    if (int'(level) > max_level) max_level = int'(level);
    if (tty_write && !prev_w) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: tty_data=%h with no character expected", tty_data);
      end else begin
        exp_c = exp_q.pop_front();
        if (tty_data !== {24'h0, exp_c}) begin
          fails++;
          $display("FAIL sb_data: got %h expected %h", tty_data, {24'h0, exp_c});
        end
      end
      if (gap_check_en && lo_valid) begin
        checks++;
        if (lo_cnt != GAP + 1) begin
          fails++;
          $display("FAIL gap_len: got %0d low cycles expected %0d", lo_cnt, GAP + 1);
        end
      end
      held = tty_data;
      hi_cnt = 1;
      n_pulses++;
    end else if (tty_write) begin
      hi_cnt++;
    end else if (prev_w) begin
      checks++;
      if (hi_cnt != HOLD) begin
        fails++;
        $display("FAIL hold_len: got %0d high cycles expected %0d", hi_cnt, HOLD);
      end
      checks++;
      if (tty_data !== held) begin
        fails++;
        $display("FAIL data_stable: got %h expected %h", tty_data, held);
      end
      lo_cnt = 1;
      lo_valid = 1'b1;
    end else begin
      lo_cnt++;
    end
    prev_w = tty_write;
  endtask

  task automatic clear_monitor();
    prev_w = 1'b0; hi_cnt = 0; lo_cnt = 0; lo_valid = 1'b0;
  endtask

  task automatic do_reset();
    cpu_we = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_monitor();
  endtask

  task automatic drv(input logic we, input logic [7:0] d);
    cpu_we = we; cpu_data = d;
    step();
    cpu_we = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    cpu_we = 1'b0;
    while (!(exp_q.size() == 0 && !tty_write && m_busy == 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL drain_timeout: %0d characters still pending after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 10 == 9) begin
        checks++;
        if ({tty_write, empty, full, overflow, level, tty_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
          fails++;
          $display("FAIL reset_idle: w=%b e=%b f=%b o=%b lvl=%0d data=%h", tty_write, empty, full, overflow, level, tty_data);
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    drv(1'b1, 8'h41);
    checks++;
    if ({tty_write, empty, level} !== {1'b0, 1'b0, 5'd1}) begin
      fails++;
      $display("FAIL single_push: w=%b e=%b lvl=%0d expected w=0 e=0 lvl=1", tty_write, empty, level);
    end
    step();
    checks++;
    if ({tty_write, level, tty_data} !== {1'b1, 5'd0, 32'h41}) begin
      fails++;
      $display("FAIL single_rise: w=%b lvl=%0d data=%h expected w=1 lvl=0 data=41", tty_write, level, tty_data);
    end
    repeat (HOLD - 1) step();
    checks++;
    if (tty_write !== 1'b1) begin
      fail_w("single_last_high", tty_write, 1'b1);
    end
    step();
    checks++;
    if (tty_write !== 1'b0) fail_w("single_fall", tty_write, 1'b0);
    repeat (GAP - 1) step();
    checks++;
    if ({tty_write, tty_data} !== {1'b0, 32'h41}) begin
      fails++;
      $display("FAIL single_gap: w=%b data=%h expected w=0 data=41", tty_write, tty_data);
    end
    drain(50);
  endtask

  task automatic fail_w(input string name, input logic got, input logic want);
    fails++;
    $display("FAIL %s: got %b expected %b", name, got, want);
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [7:0] msg [5];
    do_reset();
    msg[0] = "H"; msg[1] = "E"; msg[2] = "L"; msg[3] = "L"; msg[4] = "O";
    p0 = n_pulses;
    max_level = 0;
    gap_check_en = 1'b1;
    for (int i = 0; i < 5; i++) drv(1'b1, msg[i]);
    drain(100);
    gap_check_en = 1'b0;
    checks++;
    if (n_pulses - p0 != 5) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d expected 5", n_pulses - p0);
    end
    checks++;
    if (max_level != 4) begin
      fails++;
      $display("FAIL b2b_peak_level: got %0d expected 4", max_level);
    end
  endtask

  task automatic test_overflow();
    int   p0;
    logic saw_full;
    do_reset();
    p0 = n_pulses;
    saw_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ovf_clr = (i == 18);
      drv(1'b1, 8'h61 + 8'(i));
      ovf_clr = 1'b0;
      if (full) saw_full = 1'b1;
      checks++;
      if ({overflow, int'(level)} !== {m_ovf, m_level}) begin
        fails++;
        $display("FAIL burst_state[%0d]: ovf=%b lvl=%0d expected ovf=%b lvl=%0d", i, overflow, level, m_ovf, m_level);
      end
    end
    checks++;
    if (saw_full !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL burst_full_ovf: saw_full=%b ovf=%b expected 1 1", saw_full, overflow);
    end
    drain(400);
    checks++;
    if (n_pulses - p0 != 19) begin
      fails++;
      $display("FAIL burst_emitted: got %0d expected 19", n_pulses - p0);
    end
    checks++;
    if (overflow !== 1'b1) fail_w("ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) fail_w("ovf_clear", overflow, 1'b0);
  endtask

  task automatic test_full_pop();
    int n;
    do_reset();
    for (int i = 0; i < 18; i++) drv(1'b1, 8'h41 + 8'(i));
    n = 0;
    while (!(m_level == DEPTH && m_busy == 0) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      fails++;
      $display("FAIL full_pop_wait: model level=%0d busy=%0d never reached full+pop", m_level, m_busy);
    end
    drv(1'b1, 8'h7A);
    checks++;
    if ({overflow, full, level} !== {1'b0, 1'b1, 5'd16}) begin
      fails++;
      $display("FAIL full_pop: ovf=%b full=%b lvl=%0d expected ovf=0 full=1 lvl=16", overflow, full, level);
    end
    drain(400);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    drv(1'b1, 8'h31);
    drv(1'b1, 8'h32);
    drv(1'b1, 8'h33);
    n = 0;
    while (!(tty_write && hi_cnt == 2) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL mid_wait: second high cycle not reached, w=%b hi=%0d", tty_write, hi_cnt);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({tty_write, empty, level, tty_data} !== {1'b0, 1'b1, 5'd0, 32'd0}) begin
      fails++;
      $display("FAIL mid_reset: w=%b e=%b lvl=%0d data=%h expected 0 1 0 0", tty_write, empty, level, tty_data);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_monitor();
    drv(1'b1, 8'h0A);
    step();
    checks++;
`ifdef TTY_LF2CR_EN
    if (tty_data !== 32'h0D || tty_write !== 1'b1) begin
`else
    if (tty_data !== 32'h0A || tty_write !== 1'b1) begin
`endif
      fails++;
      $display("FAIL lf_char: w=%b data=%h expected w=1 data=%h", tty_write, tty_data, {24'h0, exp_char(8'h0A)});
    end
    drain(50);
  endtask

  initial begin
    clear_monitor();
    n_pulses = 0; max_level = 0; gap_check_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
